si_stream_arbiter: RTL and testbench
====================================

// Module: si_stream_arbiter
// PURPOSE
// - Packet-granular round-robin arbiter merging NUM_PORTS time-tag AXI4-Stream links into one stream.
// - Sits after one si_header_parser per link, ahead of the shared header_detacher/tag datapath.
// - Never interleaves packets: a grant is held from first word to the tlast handshake.
// - Tags each output word with its source port and counts forwarded packets per port.
// PARAMETERS
// - NUM_PORTS   2    number of input links, 2..4
// - DATA_WIDTH  128  tdata width; only 128 is supported, any other value -> $error and $finish
// - KEEP_WIDTH  (DATA_WIDTH+7)/8  tkeep width
// - ID_WIDTH    (NUM_PORTS>2)?2:1  width of m_axis_tid
// PORTS
// - clk             in   1                     single clock domain
// - rst_n           in   1                     asynchronous, active-low reset
// - port_enable     in   NUM_PORTS             per-port arbitration enable
// - s_axis_tvalid   in   NUM_PORTS             per-port valid
// - s_axis_tready   out  NUM_PORTS             per-port ready
// - s_axis_tdata    in   NUM_PORTS*DATA_WIDTH  port i in slice [i*DATA_WIDTH +: DATA_WIDTH]
// - s_axis_tkeep    in   NUM_PORTS*KEEP_WIDTH  same packing as tdata
// - s_axis_tlast    in   NUM_PORTS             per-port last
// - m_axis_tvalid   out  1                     registered
// - m_axis_tready   in   1
// - m_axis_tdata    out  DATA_WIDTH            registered
// - m_axis_tkeep    out  KEEP_WIDTH            registered
// - m_axis_tlast    out  1                     registered
// - m_axis_tid      out  ID_WIDTH              source port of the current word
// - pkt_count       out  NUM_PORTS*32          forwarded packets per port; wraps; port i in [i*32 +: 32]
// - busy            out  1                     high while the FSM is in LOCKED
// BEHAVIOUR
// - Reset (rst_n low, async): all outputs 0; state IDLE; grant 0; rr_ptr 0 (port 0 has first priority).
// - FSM IDLE:
//   - Search from rr_ptr upward, with wrap, for the first i where s_axis_tvalid[i] && port_enable[i].
//   - If found, register grant = i and go to LOCKED; otherwise stay in IDLE.
//   - s_axis_tready is all 0 in IDLE: one bubble cycle per packet. This is required behaviour.
// - FSM LOCKED:
//   - s_axis_tready[grant] = ~m_axis_tvalid | m_axis_tready; all other readies are 0.
//   - On an input handshake, the output register loads tdata/tkeep/tlast, tid = grant, and m_axis_tvalid = 1.
//   - The output register clears m_axis_tvalid on an output handshake with no new load.
//   - Full-throughput streaming inside a packet; latency input to output is 1 cycle.
//   - On an input handshake with tlast: rr_ptr <= grant+1 (wrapping at NUM_PORTS), pkt_count[grant]++, next state IDLE.
//   - Deasserting port_enable[grant] mid-packet has no effect; the packet completes.
// - Outputs remain stable while m_axis_tvalid && ~m_axis_tready (AXI4-Stream rule).
// - A 1-word packet (tlast on the first word) is legal: IDLE -> LOCKED -> IDLE.
// - pkt_count wraps from 0xFFFF_FFFF to 0 silently.
// - Simultaneous valid on several ports: priority goes to the lowest index >= rr_ptr, then wraps.
//   - Result: strict fairness, at most NUM_PORTS-1 packets waited.
// - No valid-and-enabled port: IDLE is held indefinitely and m_axis_tvalid drops once drained.
// - Async reset mid-packet: the partial packet is lost and m_axis_tvalid goes 0 immediately.
//   - Upstream parsers are reset together with this block.
// TESTING
// - Single port: 4-word packet on port 0, m_axis_tready=1.
//   - Expect 4 output words, 1 cycle latency, tid=0, tlast on word 4, pkt_count[0]=1.
// - Fairness: ports 0 and 1 each continuously offer 3-word packets.
//   - Expect output order 0,1,0,1 by packet, no interleaved words, a 1-cycle gap between packets.
// - Backpressure: toggle m_axis_tready with a 50% random pattern during a 10-word packet.
//   - Expect data/keep/last/tid stable while stalled and all 10 words in order.
// - Enable mask: port_enable=2'b10 with both ports valid -> only port 1 is served.
//   - Clearing port_enable[1] mid-packet -> that packet still completes.
// - Counter wrap: force pkt_count[1]=0xFFFF_FFFF, send one packet on port 1 -> pkt_count[1]=0.
// - Reset mid-packet: assert rst_n=0 at word 2 of 5.
//   - Expect m_axis_tvalid=0 asynchronously and state IDLE.
//   - The next packet on port 0 is granted first.

Source files
------------

// File: rtl/si_stream_arbiter.sv
// si_stream_arbiter: packet-granular round-robin merge of NUM_PORTS AXI4-Stream
// links into one registered output stream. A grant is held from the first word
// of a packet until its tlast handshake; each output word carries its source
// port in m_axis_tid and every forwarded packet bumps that port's counter.
module si_stream_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH   = (NUM_PORTS > 2) ? 2 : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             port_enable,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [NUM_PORTS*32-1:0]          pkt_count,
  output logic                             busy
);

  // The datapath is only qualified for 128-bit words.
  if (DATA_WIDTH != 128) begin : g_bad_width
    $error("si_stream_arbiter: DATA_WIDTH must be 128");
  end

  typedef enum logic [0:0] {IDLE, LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     grant_q, grant_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q;
  logic [NUM_PORTS-1:0]    req;

  logic                    sel_valid;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [KEEP_WIDTH-1:0]   sel_keep;
  logic                    out_free;
  logic                    in_hs;
  logic                    pkt_done;

  logic                    vld_p1;
  logic [DATA_WIDTH-1:0]   data_p1;
  logic [KEEP_WIDTH-1:0]   keep_p1;
  logic                    last_p1;
  logic [ID_WIDTH-1:0]     tid_p1;

  assign req      = s_axis_tvalid & port_enable;
  assign out_free = ~vld_p1 | m_axis_tready;
  assign in_hs    = (state_q == LOCKED) && sel_valid && out_free;
  assign pkt_done = in_hs && sel_last;

  // Route the granted port's stream onto the shared input bus.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
      end
    end
  end

  // Only the granted port sees ready, and only while LOCKED; IDLE is the bubble.
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if ((state_q == LOCKED) && (grant_q == ID_WIDTH'(i))) begin
        s_axis_tready[i] = out_free;
      end
    end
  end

  // Next state: round-robin search from rr_ptr in IDLE, release on tlast in LOCKED.
  always_comb begin
    logic              found;
    int                idx_i;
    logic [ID_WIDTH-1:0] idx;
    state_d = state_q;
    grant_d = grant_q;
    found   = 1'b0;
    idx_i   = 0;
    idx     = '0;
    case (state_q)
      IDLE: begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx_i = int'(rr_ptr_q) + k;
          if (idx_i >= NUM_PORTS) idx_i = idx_i - NUM_PORTS;
          idx = ID_WIDTH'(idx_i);
          if (!found && req[idx]) begin
            found   = 1'b1;
            grant_d = idx;
          end
        end
        if (found) state_d = LOCKED;
      end
      LOCKED: begin
        if (pkt_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, grant and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (pkt_done) begin
        rr_ptr_q <= (grant_q == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  // ---- stage p1: output register, loads on input handshake, drains on output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      keep_p1 <= '0;
      last_p1 <= 1'b0;
      tid_p1  <= '0;
    end else if (in_hs) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      keep_p1 <= sel_keep;
      last_p1 <= sel_last;
      tid_p1  <= grant_q;
    end else if (m_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  // Per-port forwarded-packet counters, wrapping silently.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
    logic [31:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (pkt_done && (grant_q == ID_WIDTH'(p))) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign pkt_count[p*32 +: 32] = cnt_q;
  end

  assign m_axis_tvalid = vld_p1;
  assign m_axis_tdata  = data_p1;
  assign m_axis_tkeep  = keep_p1;
  assign m_axis_tlast  = last_p1;
  assign m_axis_tid    = tid_p1;
  assign busy          = (state_q == LOCKED);

endmodule

// File: tb/tb_si_stream_arbiter.sv
// Directed bench for si_stream_arbiter with two ports: table-driven cycle
// vectors plus hand sequences for backpressure and asynchronous reset.
module tb_si_stream_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   port_enable;
  logic [1:0]   s_axis_tvalid;
  logic [1:0]   s_axis_tready;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [1:0]   s_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic [0:0]   m_axis_tid;
  logic [63:0]  pkt_count;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  si_stream_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(128)) dut (
    .clk(clk), .rst_n(rst_n), .port_enable(port_enable),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .pkt_count(pkt_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  en;
    logic [1:0]  v;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  l;
    logic        mr;
    logic [1:0]  srdy;
    logic        mv;
    logic [31:0] md;
    logic        ml;
    logic        mid;
    logic        bsy;
    logic [31:0] c0;
    logic [31:0] c1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] en, input logic [1:0] v,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] l,
                              input logic mr, input logic [1:0] srdy, input logic mv,
                              input logic [31:0] md, input logic ml, input logic mid,
                              input logic bsy, input logic [31:0] c0, input logic [31:0] c1);
    vec_t r;
    r.rst = rst; r.en = en; r.v = v; r.d0 = d0; r.d1 = d1; r.l = l; r.mr = mr;
    r.srdy = srdy; r.mv = mv; r.md = md; r.ml = ml; r.mid = mid; r.bsy = bsy;
    r.c0 = c0; r.c1 = c1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_ports(input logic [1:0] v, input logic [31:0] d0,
                             input logic [31:0] d1, input logic [1:0] l);
    s_axis_tvalid = v;
    s_axis_tdata  = {{4{d1}}, {4{d0}}};
    s_axis_tkeep  = {d1[15:0], d0[15:0]};
    s_axis_tlast  = l;
  endtask

  // One vector = one clock: inputs driven at negedge, ready checked before the
  // rising edge, registered outputs and counters checked just after it.
  task automatic apply_vec(input vec_t v, input string nm);
    @(negedge clk);
    rst_n         = v.rst;
    port_enable   = v.en;
    m_axis_tready = v.mr;
    drive_ports(v.v, v.d0, v.d1, v.l);
    #1;
    chk({nm, ".s_ready"}, 128'(s_axis_tready), 128'(v.srdy));
    @(posedge clk);
    #1;
    chk({nm, ".m_valid"}, 128'(m_axis_tvalid), 128'(v.mv));
    chk({nm, ".busy"}, 128'(busy), 128'(v.bsy));
    chk({nm, ".cnt0"}, 128'(pkt_count[31:0]), 128'(v.c0));
    chk({nm, ".cnt1"}, 128'(pkt_count[63:32]), 128'(v.c1));
    if (v.mv) begin
      chk({nm, ".data"}, m_axis_tdata, {4{v.md}});
      chk({nm, ".keep"}, 128'(m_axis_tkeep), 128'(v.md[15:0]));
      chk({nm, ".last"}, 128'(m_axis_tlast), 128'(v.ml));
      chk({nm, ".tid"}, 128'(m_axis_tid), 128'(v.mid));
    end
  endtask

  task automatic run_tbl(input string nm);
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("%s[%0d]", nm, i));
    tbl.delete();
  endtask

  initial begin
    int sent;
    int got;
    logic in_hs;
    logic out_hs;

    rst_n = 1'b0; port_enable = 2'b00; m_axis_tready = 1'b0;
    drive_ports(2'b00, 32'h0, 32'h0, 2'b00);

    // Single port: 4-word packet on port 0, 1-cycle latency, then drain.
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 1, 1, 0, 0, 1,  1, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 1, 2, 0, 0, 1,  1, 1, 2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 1, 3, 0, 0, 1,  1, 1, 3, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 1, 4, 0, 1, 1,  1, 1, 4, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1, 0));
    run_tbl("single");

    // Fairness: both ports offer 3-word packets back to back -> 0,1,0.
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 3, 'h10, 'h20, 0, 1,  0, 0, 0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 3, 'h10, 'h20, 0, 1,  1, 1, 'h10, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 3, 'h11, 'h20, 0, 1,  1, 1, 'h11, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 3, 'h12, 'h20, 1, 1,  1, 1, 'h12, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 3, 3, 'h10, 'h20, 0, 1,  0, 0, 0,    0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 3, 3, 'h10, 'h20, 0, 1,  2, 1, 'h20, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 3, 3, 'h10, 'h21, 0, 1,  2, 1, 'h21, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 3, 3, 'h10, 'h22, 2, 1,  2, 1, 'h22, 1, 1, 0, 1, 1));
    tbl.push_back(mk(1, 3, 3, 'h10, 'h20, 0, 1,  0, 0, 0,    0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 3, 3, 'h10, 'h20, 0, 1,  1, 1, 'h10, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 3, 3, 'h11, 'h20, 0, 1,  1, 1, 'h11, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 3, 3, 'h12, 'h20, 1, 1,  1, 1, 'h12, 1, 0, 0, 2, 1));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 2, 1));
    run_tbl("fair");

    // Enable mask: only port 1 enabled; enable dropped mid-packet, packet completes.
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 3, 'h30, 'h40, 1, 1,  0, 0, 0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 2, 3, 'h30, 'h40, 1, 1,  2, 1, 'h40, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 3, 'h30, 'h41, 1, 1,  2, 1, 'h41, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 3, 'h30, 'h42, 3, 1,  2, 1, 'h42, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3, 'h30, 'h40, 1, 1,  0, 0, 0,    0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 3, 'h30, 'h40, 1, 1,  0, 0, 0,    0, 0, 0, 0, 1));
    run_tbl("enable");

    // Counter wrap on port 1 with a 1-word packet.
    force dut.g_cnt[1].cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.g_cnt[1].cnt_q;
    tbl.push_back(mk(1, 3, 2, 0, 'h50, 2, 1,  0, 0, 0,    0, 0, 1, 0, 32'hFFFF_FFFF));
    tbl.push_back(mk(1, 3, 2, 0, 'h50, 2, 1,  2, 1, 'h50, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
    run_tbl("wrap");

    // Reset mid-packet: word 2 of 5 is out, then rst_n drops between edges.
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 1, 'h60, 0, 0, 1,  0, 0, 0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 1, 'h60, 0, 0, 1,  1, 1, 'h60, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 1, 'h61, 0, 0, 1,  1, 1, 'h61, 0, 0, 1, 0, 0));
    run_tbl("rstmid");
    @(negedge clk);
    drive_ports(2'b01, 32'h62, 32'h0, 2'b00);
    rst_n = 1'b0;
    #1;
    chk("rstmid.async_valid", 128'(m_axis_tvalid), 128'd0);
    chk("rstmid.async_busy", 128'(busy), 128'd0);
    chk("rstmid.async_ready", 128'(s_axis_tready), 128'd0);
    tbl.push_back(mk(1, 3, 3, 'h70, 'h80, 3, 1,  0, 0, 0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 3, 'h70, 'h80, 3, 1,  1, 1, 'h70, 1, 0, 0, 1, 0));
    run_tbl("rstnext");

    // Backpressure: 10-word packet on port 0 against a random m_axis_tready.
    apply_vec(mk(0, 3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0), "bp.reset");
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      @(negedge clk);
      rst_n         = 1'b1;
      m_axis_tready = 1'($urandom_range(0, 1));
      drive_ports({1'b0, sent < 10}, 32'h100 + 32'(sent), 32'h0, {1'b0, sent == 9});
      #1;
      if (m_axis_tvalid) begin
        chk($sformatf("bp.data%0d", got), m_axis_tdata, {4{32'h100 + 32'(got)}});
        chk($sformatf("bp.keep%0d", got), 128'(m_axis_tkeep), 128'(16'h100 + 16'(got)));
        chk($sformatf("bp.last%0d", got), 128'(m_axis_tlast), 128'(got == 9));
        chk($sformatf("bp.tid%0d", got), 128'(m_axis_tid), 128'd0);
      end
      in_hs  = s_axis_tready[0] & s_axis_tvalid[0];
      out_hs = m_axis_tvalid & m_axis_tready;
      @(posedge clk);
      if (in_hs) sent++;
      if (out_hs) got++;
    end
    chk("bp.words_received", 128'(got), 128'd10);
    chk("bp.cnt0", 128'(pkt_count[31:0]), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
